// File: rtl/mcs4_pkg.sv
// mcs4_pkg: shared definitions for the MCS-4 two-phase clock generator.
//   state_t          phase FSM states (IDLE, PH1, GAP1, PH2, GAP2)
//   DEF_*_CYCLES     default phase/gap lengths in sysclk cycles
//   DEF_POC_PERIODS  default number of complete clock periods poc_pad is held
//   max_of4()        helper for sizing the shared phase counter
package mcs4_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PH1,
    GAP1,
    PH2,
    GAP2
  } state_t;

  localparam int DEF_P1_CYCLES   = 8;
  localparam int DEF_G1_CYCLES   = 2;
  localparam int DEF_P2_CYCLES   = 8;
  localparam int DEF_G2_CYCLES   = 2;
  localparam int DEF_POC_PERIODS = 64;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/mcs4_poc_ctl.sv
// mcs4_poc_ctl: power-on-clear controller.
// Holds poc_pad high for POC_PERIODS complete clock periods after reset or
// after a poc_req pulse.
//   sysclk       in   system clock
//   rst_n        in   asynchronous active-low reset
//   poc_req      in   one-cycle pulse, restarts the POC sequence
//   period_done  in   strobe on the last GAP2 cycle of every period
//   poc_pad      out  power-on clear, active high (registered)
module mcs4_poc_ctl
  import mcs4_pkg::*;
#(
  parameter int POC_PERIODS = DEF_POC_PERIODS
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic poc_req,
  input  logic period_done,
  output logic poc_pad
);

  localparam int PW = $clog2(POC_PERIODS + 1);

  logic [PW-1:0] poc_cnt;

  // poc_req wins over a coincident period_done so a restart is never
  // shortened by one period. poc_pad drops on the same edge the count hits
  // zero, i.e. together with the last GAP2 exit.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      poc_cnt <= PW'(POC_PERIODS);
      poc_pad <= 1'b1;
    end else if (poc_req) begin
      poc_cnt <= PW'(POC_PERIODS);
      poc_pad <= 1'b1;
    end else if (period_done && poc_pad) begin
      poc_cnt <= poc_cnt - PW'(1);
      if (poc_cnt == PW'(1)) poc_pad <= 1'b0;
    end
  end

endmodule

// File: rtl/mcs4_clock_gen.sv
// mcs4_clock_gen: two-phase non-overlapping clock source for the 4004 core.
// clk1_pad/clk2_pad are sysclk-synchronous levels used downstream as enables.
//   sysclk        in   system clock, all state on posedge
//   rst_n         in   asynchronous active-low reset
//   run           in   1 = free-running; 0 = halt at end of current period
//   step          in   one-cycle pulse; while halted runs exactly one period
//   poc_req       in   one-cycle pulse; restarts the power-on-clear sequence
//   clk1_pad      out  phase-1 clock level
//   clk2_pad      out  phase-2 clock level
//   poc_pad       out  power-on clear, active high
//   period_start  out  one-cycle pulse on the first sysclk of each PH1
//   halted        out  generator parked in IDLE
module mcs4_clock_gen
  import mcs4_pkg::*;
#(
  parameter int P1_CYCLES   = DEF_P1_CYCLES,
  parameter int G1_CYCLES   = DEF_G1_CYCLES,
  parameter int P2_CYCLES   = DEF_P2_CYCLES,
  parameter int G2_CYCLES   = DEF_G2_CYCLES,
  parameter int POC_PERIODS = DEF_POC_PERIODS
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic run,
  input  logic step,
  input  logic poc_req,
  output logic clk1_pad,
  output logic clk2_pad,
  output logic poc_pad,
  output logic period_start,
  output logic halted
);

  localparam int MAX_CYCLES = max_of4(P1_CYCLES, G1_CYCLES, P2_CYCLES, G2_CYCLES);
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] P1_LOAD = CW'(P1_CYCLES - 1);
  localparam logic [CW-1:0] G1_LOAD = CW'(G1_CYCLES - 1);
  localparam logic [CW-1:0] P2_LOAD = CW'(P2_CYCLES - 1);
  localparam logic [CW-1:0] G2_LOAD = CW'(G2_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] phase_cnt;
  logic          step_pending;
  logic          go;
  logic          cnt_zero;
  logic          period_done;

  // The generator keeps running through the whole POC sequence even when
  // run is low, so the core sees clocks while it is being cleared.
  assign go          = run | poc_pad | step_pending;
  assign cnt_zero    = (phase_cnt == '0);
  assign period_done = (state == GAP2) && cnt_zero;

  mcs4_poc_ctl #(
    .POC_PERIODS (POC_PERIODS)
  ) u_poc_ctl (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .poc_req     (poc_req),
    .period_done (period_done),
    .poc_pad     (poc_pad)
  );

  // Phase FSM. Outputs are registered alongside the state so each clock
  // level changes on the same edge as the state it belongs to.
  // step is only latched while parked in IDLE: once the stepped period has
  // begun, further pulses of a burst are dropped, so a burst yields one
  // period. Entering PH1 clears step_pending after the latch assignment, so
  // a pulse landing on the consuming edge merges into that period.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      phase_cnt    <= '0;
      step_pending <= 1'b0;
      clk1_pad     <= 1'b0;
      clk2_pad     <= 1'b0;
      period_start <= 1'b0;
      halted       <= 1'b0;
    end else begin
      period_start <= 1'b0;
      if (step && state == IDLE) step_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (go) begin
            state        <= PH1;
            phase_cnt    <= P1_LOAD;
            clk1_pad     <= 1'b1;
            period_start <= 1'b1;
            halted       <= 1'b0;
            step_pending <= 1'b0;
          end else begin
            halted <= 1'b1;
          end
        end

        PH1: begin
          if (cnt_zero) begin
            state     <= GAP1;
            phase_cnt <= G1_LOAD;
            clk1_pad  <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt - CW'(1);
          end
        end

        GAP1: begin
          if (cnt_zero) begin
            state     <= PH2;
            phase_cnt <= P2_LOAD;
            clk2_pad  <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - CW'(1);
          end
        end

        PH2: begin
          if (cnt_zero) begin
            state     <= GAP2;
            phase_cnt <= G2_LOAD;
            clk2_pad  <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt - CW'(1);
          end
        end

        GAP2: begin
          if (cnt_zero) begin
            if (go) begin
              state        <= PH1;
              phase_cnt    <= P1_LOAD;
              clk1_pad     <= 1'b1;
              period_start <= 1'b1;
              step_pending <= 1'b0;
            end else begin
              state  <= IDLE;
              halted <= 1'b1;
            end
          end else begin
            phase_cnt <= phase_cnt - CW'(1);
          end
        end

        default: begin
          state     <= IDLE;
          phase_cnt <= '0;
          clk1_pad  <= 1'b0;
          clk2_pad  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcs4_clock_gen.sv
// tb_mcs4_clock_gen: scoreboard bench for mcs4_clock_gen.
// DUT A uses the default 8/2/8/2 timing; DUT B uses 1/1/1/1 and free-runs.
// The stimulus process queues expected output snapshots tagged with the
// cycle number they belong to; the monitor samples both DUTs on every
// falling sysclk edge and checks any snapshot that is due.
// Cycle numbering: cycle 0 is while reset is applied, cycle N is the
// interval after the Nth rising edge following reset release.
module tb_mcs4_clock_gen;

  localparam int P1     = 8;
  localparam int G1     = 2;
  localparam int P2     = 8;
  localparam int PERIOD = 20;

  typedef struct {
    int         cycle;
    logic [4:0] bits;   // {clk1, clk2, poc, halted, period_start}
    int         np;     // period_start pulses seen since reset, inclusive
  } exp_t;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  logic run    = 1'b1;
  logic step   = 1'b0;
  logic poc_req = 1'b0;
  logic run_b  = 1'b1;
  logic step_b = 1'b0;
  logic poc_req_b = 1'b0;

  logic clk1_a, clk2_a, poc_a, pstart_a, halted_a;
  logic clk1_b, clk2_b, poc_b, pstart_b, halted_b;

  int cyc = 0;
  int np_a = 0;
  int np_b = 0;
  int compared = 0;
  int mismatched = 0;

  exp_t qa[$];
  exp_t qb[$];

  mcs4_clock_gen dut_a (
    .sysclk       (sysclk),
    .rst_n        (rst_n),
    .run          (run),
    .step         (step),
    .poc_req      (poc_req),
    .clk1_pad     (clk1_a),
    .clk2_pad     (clk2_a),
    .poc_pad      (poc_a),
    .period_start (pstart_a),
    .halted       (halted_a)
  );

  mcs4_clock_gen #(
    .P1_CYCLES (1),
    .G1_CYCLES (1),
    .P2_CYCLES (1),
    .G2_CYCLES (1)
  ) dut_b (
    .sysclk       (sysclk),
    .rst_n        (rst_n),
    .run          (run_b),
    .step         (step_b),
    .poc_req      (poc_req_b),
    .clk1_pad     (clk1_b),
    .clk2_pad     (clk2_b),
    .poc_pad      (poc_b),
    .period_start (pstart_b),
    .halted       (halted_b)
  );

  always #5 sysclk = ~sysclk;

  // Cycle index restarts asynchronously with the DUT reset.
  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic checkOutput(input string who, input exp_t e, input logic [4:0] act, input int np_act);
    compared++;
    if (e.cycle != cyc || act !== e.bits || np_act != e.np) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d (due %0d): clk1/clk2/poc/halted/pstart=%b periods=%0d, required %b periods=%0d",
               who, cyc, e.cycle, act, np_act, e.bits, e.np);
    end
  endtask

  // Monitor: overlap check on both DUTs every cycle, then due snapshots.
  initial begin
    exp_t e;
    forever begin
      @(negedge sysclk);
      if (cyc == 0) begin
        np_a = 0;
        np_b = 0;
      end else begin
        np_a += int'(pstart_a);
        np_b += int'(pstart_b);
      end
      compared += 2;
      if (clk1_a && clk2_a) begin
        mismatched++;
        $display("[TB] FAIL overlap_a cycle %0d: clk1=%b clk2=%b, required not both 1", cyc, clk1_a, clk2_a);
      end
      if (clk1_b && clk2_b) begin
        mismatched++;
        $display("[TB] FAIL overlap_b cycle %0d: clk1=%b clk2=%b, required not both 1", cyc, clk1_b, clk2_b);
      end
      while (qa.size() > 0 && qa[0].cycle <= cyc) begin
        e = qa.pop_front();
        checkOutput("A", e, {clk1_a, clk2_a, poc_a, halted_a, pstart_a}, np_a);
      end
      while (qb.size() > 0 && qb[0].cycle <= cyc) begin
        e = qb.pop_front();
        checkOutput("B", e, {clk1_b, clk2_b, poc_b, halted_b, pstart_b}, np_b);
      end
    end
  end

  // Expected running snapshot of DUT A for a period train starting at 'start'.
  task automatic pushRunA(input int c, input int start, input int np0, input logic poc);
    int o;
    int ph;
    logic [4:0] b;
    o  = c - start;
    ph = o % PERIOD;
    b  = {ph < P1, (ph >= P1 + G1) && (ph < P1 + G1 + P2), poc, 1'b0, ph == 0};
    qa.push_back('{c, b, np0 + o / PERIOD});
  endtask

  task automatic pushIdleA(input int c, input int np);
    qa.push_back('{c, 5'b00010, np});
  endtask

  task automatic pushB(input int c, input logic poc);
    int ph;
    logic [4:0] b;
    ph = (c - 1) % 4;
    b  = {ph == 0, ph == 2, poc, 1'b0, ph == 0};
    qb.push_back('{c, b, (c - 1) / 4 + 1});
  endtask

  // Waits for the falling edge of cycle 'at', then drives the inputs.
  task automatic applyStimulus(input int at, input logic r, input logic s, input logic p);
    int guard;
    guard = 0;
    do begin
      @(negedge sysclk);
      guard++;
    end while (cyc < at && guard < 5000);
    compared++;
    if (cyc != at) begin
      mismatched++;
      $display("[TB] FAIL stim_timing: reached cycle %0d, required %0d", cyc, at);
    end
    run     = r;
    step    = s;
    poc_req = p;
  endtask

  initial begin
    // Reset state, first two periods, and end of the initial POC window.
    qa.push_back('{0, 5'b00100, 0});
    for (int c = 1; c <= 2 * PERIOD; c++) pushRunA(c, 1, 1, 1'b1);
    for (int c = 1279; c <= 1282; c++) pushRunA(c, 1, 1, c <= 1280);
    qb.push_back('{0, 5'b00100, 0});
    for (int c = 1; c <= 8; c++) pushB(c, 1'b1);
    pushB(256, 1'b1);
    pushB(257, 1'b0);

    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    $display("[TB] reset released");

    // poc_req during period 100 holds poc_pad for another 64 period ends.
    pushRunA(1985, 1, 1, 1'b0);
    pushRunA(1986, 1, 1, 1'b1);
    pushRunA(2001, 1, 1, 1'b1);
    pushRunA(3260, 1, 1, 1'b1);
    pushRunA(3261, 1, 1, 1'b0);
    applyStimulus(1985, 1'b1, 1'b0, 1'b1);
    applyStimulus(1986, 1'b1, 1'b0, 1'b0);

    // run dropped mid-PH2 of period 164: period completes, then parks.
    for (int c = 3278; c <= 3280; c++) pushRunA(c, 1, 1, 1'b0);
    pushIdleA(3281, 164);
    pushIdleA(3330, 164);
    applyStimulus(3273, 1'b0, 1'b0, 1'b0);

    // run restored: PH1 on the following cycle; dropped again right away.
    pushRunA(3341, 3341, 165, 1'b0);
    pushRunA(3342, 3341, 165, 1'b0);
    pushRunA(3358, 3341, 165, 1'b0);
    pushRunA(3360, 3341, 165, 1'b0);
    pushIdleA(3361, 165);
    applyStimulus(3340, 1'b1, 1'b0, 1'b0);
    applyStimulus(3342, 1'b0, 1'b0, 1'b0);

    // Single step while halted: exactly one period.
    pushIdleA(3371, 165);
    pushRunA(3372, 3372, 166, 1'b0);
    pushRunA(3373, 3372, 166, 1'b0);
    pushRunA(3391, 3372, 166, 1'b0);
    pushIdleA(3392, 166);
    pushIdleA(3400, 166);
    applyStimulus(3370, 1'b0, 1'b1, 1'b0);
    applyStimulus(3371, 1'b0, 1'b0, 1'b0);

    // Burst of three steps: still only one period.
    pushIdleA(3411, 166);
    pushRunA(3412, 3412, 167, 1'b0);
    pushRunA(3431, 3412, 167, 1'b0);
    pushIdleA(3432, 167);
    pushIdleA(3450, 167);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(3410 + 2 * k, 1'b0, 1'b1, 1'b0);
      applyStimulus(3411 + 2 * k, 1'b0, 1'b0, 1'b0);
    end

    // Restart, then a short reset pulse mid-PH1 that misses every rising edge.
    pushRunA(3461, 3461, 168, 1'b0);
    pushRunA(3463, 3461, 168, 1'b0);
    applyStimulus(3460, 1'b1, 1'b0, 1'b0);
    applyStimulus(3463, 1'b1, 1'b0, 1'b0);
    @(posedge sysclk);
    compared++;
    if (qa.size() != 0 || qb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain_before_reset: pending A=%0d B=%0d, required 0", qa.size(), qb.size());
    end
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    $display("[TB] mid-period reset pulse applied");
    qa.push_back('{0, 5'b00100, 0});
    for (int c = 1; c <= PERIOD; c++) pushRunA(c, 1, 1, 1'b1);
    pushRunA(1280, 1, 1, 1'b1);
    pushRunA(1281, 1, 1, 1'b0);
    qb.push_back('{0, 5'b00100, 0});
    for (int c = 1; c <= 4; c++) pushB(c, 1'b1);
    applyStimulus(1285, 1'b1, 1'b0, 1'b0);

    repeat (2) @(negedge sysclk);
    compared++;
    if (qa.size() != 0 || qb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain_at_end: pending A=%0d B=%0d, required 0", qa.size(), qb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
